// File: rtl/core_bus_pkg.sv
// core_bus_pkg: shared encodings for the core data-bus Wishbone bridge
package core_bus_pkg;
    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } mem_op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} bridge_state_e;
    localparam logic [3:0] SEL_B  = 4'b0001;
    localparam logic [3:0] SEL_LO = 4'b0011;
    localparam logic [3:0] SEL_HI = 4'b1100;
    localparam logic [3:0] SEL_W  = 4'b1111;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane/select generation, load extraction/extension and misalignment detection
module lsu_align import core_bus_pkg::*; (
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdat,
    output logic [31:0] o_rdata,
    output logic        o_misaligned
);
    logic        w_b, w_h;
    logic [15:0] w_sh;
    assign w_b = (i_op == OP_B) || (i_op == OP_BU);
    assign w_h = (i_op == OP_H) || (i_op == OP_HU);
    assign w_sh = 16'(i_rword >> {i_addr, 3'b000});
    assign o_sel = w_b ? SEL_B << i_addr : w_h ? (i_addr[1] ? SEL_HI : SEL_LO) : SEL_W;
    assign o_wdat = w_b ? {4{i_wdata[7:0]}} : w_h ? {2{i_wdata[15:0]}} : i_wdata;
    // funct3[2] distinguishes the unsigned variants; undefined ops fall through as words
    assign o_rdata = w_b ? {{24{~i_op[2] & w_sh[7]}}, w_sh[7:0]} :
                     w_h ? {{16{~i_op[2] & w_sh[15]}}, w_sh} : i_rword;
    assign o_misaligned = (w_h & i_addr[0]) | (~w_b & ~w_h & |i_addr);
endmodule

// File: rtl/core_dbus_wb_bridge.sv
// core_dbus_wb_bridge: turns MEM-stage load/store requests into single Wishbone classic cycles,
// stalling the pipeline until each access completes, errors or times out.
module core_dbus_wb_bridge import core_bus_pkg::*; #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr_mem,
    input  logic [31:0] mem_wdata_mem,
    input  logic        mem_write_mem,
    input  logic        mem_read_mem,
    input  logic [2:0]  mem_op_mem,
    output logic [31:0] mem_rdata_mem,
    output logic        stall_pipl,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        bus_err,
    output logic [31:0] err_addr
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    bridge_state_e r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_addr;
    logic [2:0]    r_op;
    logic          w_idle, w_req, w_mis, w_timeout;
    logic [3:0]    w_sel;
    logic [31:0]   w_wdat, w_rdata;
    assign w_idle = r_state == ST_IDLE;
    assign w_req = mem_read_mem | mem_write_mem;
    assign w_timeout = r_cnt == CW'(TIMEOUT_CYCLES - 1);
    assign stall_pipl = (w_idle & w_req) | (r_state == ST_BUSY);
    // One aligner serves both the incoming request (IDLE) and the captured request (BUSY)
    lsu_align u_align (
        .i_op         (w_idle ? mem_op_mem : r_op),
        .i_addr       (w_idle ? mem_addr_mem[1:0] : r_addr[1:0]),
        .i_wdata      (mem_wdata_mem),
        .i_rword      (wb_dat_i),
        .o_sel        (w_sel),
        .o_wdat       (w_wdat),
        .o_rdata      (w_rdata),
        .o_misaligned (w_mis)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_op          <= '0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_adr_o      <= '0;
            wb_dat_o      <= '0;
            wb_sel_o      <= '0;
            mem_rdata_mem <= '0;
            bus_err       <= 1'b0;
            err_addr      <= '0;
        end else begin
            bus_err <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_req) begin
                    r_addr <= mem_addr_mem;
                    r_op   <= mem_op_mem;
                    if (w_mis) begin
                        bus_err       <= 1'b1;
                        err_addr      <= mem_addr_mem;
                        mem_rdata_mem <= '0;
                        r_state       <= ST_DONE;
                    end else begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= mem_write_mem;
                        wb_adr_o <= {mem_addr_mem[31:2], 2'b00};
                        wb_dat_o <= w_wdat;
                        wb_sel_o <= w_sel;
                        r_cnt    <= '0;
                        r_state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (wb_err_i || w_timeout) begin
                        wb_cyc_o      <= 1'b0;
                        wb_stb_o      <= 1'b0;
                        bus_err       <= 1'b1;
                        err_addr      <= r_addr;
                        mem_rdata_mem <= '0;
                        r_state       <= ST_DONE;
                    end else if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        if (!wb_we_o) mem_rdata_mem <= w_rdata;
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_dbus_wb_bridge.sv
// tb_core_dbus_wb_bridge: scoreboard bench with a Wishbone slave model and a request-level reference
module tb_core_dbus_wb_bridge;
    localparam int TO = 8;
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        int          kind;
        int          waits;
        logic [31:0] word;
    } bus_t;
    typedef struct {
        logic        err;
        logic [31:0] eaddr;
        logic [31:0] rdata;
        int          stall;
    } done_t;
    logic        clk = 0, reset = 1;
    logic [31:0] mem_addr_mem = 0, mem_wdata_mem = 0;
    logic        mem_write_mem = 0, mem_read_mem = 0;
    logic [2:0]  mem_op_mem = 0;
    logic [31:0] mem_rdata_mem, wb_adr_o, wb_dat_o, err_addr;
    logic        stall_pipl, wb_cyc_o, wb_stb_o, wb_we_o, bus_err;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = 0;
    logic        wb_ack_i = 0, wb_err_i = 0;
    bus_t        bus_q[$];
    done_t       done_q[$];
    int          n_tests = 0, n_fail = 0;
    logic [31:0] m_rdata = 0, m_eaddr = 0;
    bit          mon_en = 0, slave_en = 1, force_ack = 0, req_active = 0;

    core_dbus_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .mem_addr_mem(mem_addr_mem), .mem_wdata_mem(mem_wdata_mem),
        .mem_write_mem(mem_write_mem), .mem_read_mem(mem_read_mem), .mem_op_mem(mem_op_mem),
        .mem_rdata_mem(mem_rdata_mem), .stall_pipl(stall_pipl),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .bus_err(bus_err), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [68:0] act, input logic [68:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: derive lanes, selects, extension and completion from the request alone
    task automatic issue(input logic w, input logic r, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d, input int kind, input int waits, input logic [31:0] word);
        int sz, off, t;
        bus_t b;
        done_t e;
        logic [31:0] v;
        sz = (op == 3'd0 || op == 3'd4) ? 1 : (op == 3'd1 || op == 3'd5) ? 2 : 4;
        off = int'(a[1:0]);
        if (off % sz != 0) begin
            m_rdata = 0;
            m_eaddr = a;
            e.err = 1; e.eaddr = a; e.rdata = 0; e.stall = 1;
        end else begin
            b.adr = {a[31:2], 2'b00};
            b.we = w;
            b.sel = 4'((1 << sz) - 1) << off;
            b.dat = sz == 1 ? {4{d[7:0]}} : sz == 2 ? {2{d[15:0]}} : d;
            b.kind = kind; b.waits = waits; b.word = word;
            bus_q.push_back(b);
            if (kind != 0) begin
                m_rdata = 0;
                m_eaddr = a;
            end else if (!w) begin
                v = word >> (8 * off);
                if (sz == 1) v = (!op[2] && v[7]) ? (v | 32'hFFFFFF00) : (v & 32'hFF);
                if (sz == 2) v = (!op[2] && v[15]) ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
                m_rdata = v;
            end
            e.err = kind != 0; e.eaddr = m_eaddr; e.rdata = m_rdata;
            e.stall = kind == 2 ? 1 + TO : 2 + waits;
        end
        done_q.push_back(e);
        mem_write_mem = w; mem_read_mem = r; mem_op_mem = op; mem_addr_mem = a; mem_wdata_mem = d;
        req_active = 1;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (!stall_pipl) break;
        end
        if (t == 40) begin
            n_tests++; n_fail++;
            $display("FAIL completion_timeout: stall high for %0d cycles, expected release", t);
        end
        @(posedge clk); #1;
        mem_write_mem = 0; mem_read_mem = 0; req_active = 0;
    endtask

    // Wishbone slave: checks each new cycle against the reference and answers per plan
    initial begin
        bus_t cur;
        int sc;
        logic [68:0] snap;
        sc = 0; snap = 0;
        cur.kind = 2; cur.waits = 0; cur.word = 0; cur.adr = 0; cur.dat = 0; cur.we = 0; cur.sel = 0;
        forever begin
            @(negedge clk);
            if (!slave_en) begin
                wb_ack_i = force_ack; wb_err_i = 0; wb_dat_i = '1;
            end else begin
                wb_ack_i = 0; wb_err_i = 0; wb_dat_i = $urandom;
                if (wb_cyc_o && wb_stb_o) begin
                    if (sc == 0) begin
                        if (bus_q.size() == 0) begin
                            n_tests++; n_fail++;
                            $display("FAIL unexpected_cycle: got cycle at adr %0h expected none", wb_adr_o);
                            cur.kind = 2;
                        end else begin
                            cur = bus_q.pop_front();
                            chk("adr", wb_adr_o, cur.adr);
                            chk("we", wb_we_o, cur.we);
                            chk("sel", wb_sel_o, cur.sel);
                            if (cur.we) chk("dat", wb_dat_o, cur.dat);
                        end
                        snap = {wb_adr_o, wb_we_o, wb_sel_o, wb_dat_o};
                    end else chk("busy_stable", {wb_adr_o, wb_we_o, wb_sel_o, wb_dat_o}, snap);
                    if (sc == cur.waits && cur.kind == 0) begin
                        wb_ack_i = 1; wb_dat_i = cur.word;
                    end
                    if (sc == cur.waits && cur.kind == 1) begin
                        wb_err_i = 1; wb_ack_i = 1'($urandom);
                    end
                    sc++;
                end
            end
            if (!(wb_cyc_o && wb_stb_o)) sc = 0;
        end
    end

    // Monitor: counts stall cycles and scores each completion against the queued expectation
    initial begin
        int sc;
        done_t e;
        sc = 0;
        forever begin
            @(negedge clk);
            if (mon_en && !reset) begin
                if (req_active && stall_pipl) begin
                    sc++;
                    chk("bus_err_while_stalled", bus_err, 0);
                end else if (req_active) begin
                    if (done_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_done: got completion expected none");
                    end else begin
                        e = done_q.pop_front();
                        chk("bus_err", bus_err, e.err);
                        chk("err_addr", err_addr, e.eaddr);
                        chk("rdata", mem_rdata_mem, e.rdata);
                        chk("stall_cycles", 69'(sc), 69'(e.stall));
                    end
                    sc = 0;
                end else begin
                    chk("idle_stall", stall_pipl, 0);
                    chk("idle_bus_err", bus_err, 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t b;
        logic        w, r;
        logic [2:0]  op;
        logic [31:0] a;
        int          k;
        repeat (3) @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_rdata", mem_rdata_mem, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_err_addr", err_addr, 0);
        chk("rst_stall", stall_pipl, 0);
        @(posedge clk); #1;
        reset = 0;
        mon_en = 1;
        issue(1, 0, 3'd2, 32'h100, 32'h11223344, 0, 0, 0);
        issue(1, 0, 3'd0, 32'h103, 32'h000000AB, 0, 0, 0);
        issue(0, 1, 3'd0, 32'h103, 0, 0, 0, 32'h80000000);
        issue(0, 1, 3'd4, 32'h103, 0, 0, 1, 32'h80000000);
        issue(0, 1, 3'd1, 32'h102, 0, 0, 0, 32'h80010000);
        issue(0, 1, 3'd1, 32'h101, 0, 0, 0, 0);
        issue(0, 1, 3'd2, 32'h104, 0, 0, 3, 32'hCAFEF00D);
        issue(0, 1, 3'd2, 32'h108, 0, 2, 0, 0);
        issue(1, 0, 3'd2, 32'h10C, 32'h55, 1, 1, 0);
        issue(1, 1, 3'd5, 32'h202, 32'h1234ABCD, 0, 0, 32'hFFFFFFFF);
        issue(0, 1, 3'd5, 32'h20E, 0, 0, 2, 32'h8001F00D);
        for (int i = 0; i < 250; i++) begin
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 2) != 0)
                a[1:0] = a[1:0] & (op[1:0] == 2'd0 ? 2'b11 : op[1:0] == 2'd1 ? 2'b10 : 2'b00);
            k = $urandom_range(0, 9);
            issue(w, r, op, a, $urandom, k < 7 ? 0 : k < 9 ? 1 : 2, $urandom_range(0, 3), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        mon_en = 0;
        b.adr = 32'h200; b.dat = 0; b.we = 0; b.sel = 4'hF; b.kind = 0; b.waits = 5; b.word = 32'h12345678;
        bus_q.push_back(b);
        mem_read_mem = 1; mem_op_mem = 3'd2; mem_addr_mem = 32'h200;
        repeat (3) @(negedge clk);
        #2;
        reset = 1; mem_read_mem = 0; slave_en = 0;
        #1;
        chk("rst_busy_cyc", wb_cyc_o, 0);
        chk("rst_busy_stb", wb_stb_o, 0);
        chk("rst_busy_stall", stall_pipl, 0);
        @(posedge clk); #1;
        reset = 0; force_ack = 1;
        repeat (2) @(negedge clk);
        chk("late_ack_cyc", wb_cyc_o, 0);
        chk("late_ack_rdata", mem_rdata_mem, 0);
        chk("late_ack_bus_err", bus_err, 0);
        chk("late_ack_stall", stall_pipl, 0);
        force_ack = 0;
        @(negedge clk);
        slave_en = 1;
        chk("bus_q_drained", 69'(bus_q.size()), 0);
        chk("done_q_drained", 69'(done_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
